// File: rtl/cpu_run_controller_pkg.sv
// cpu_ctrl_defs: shared state encoding for the CPU run controller
package cpu_ctrl_defs;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BREAK = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_run_controller_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability-counter debounce and one-cycle rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnIn,
    output logic Pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Accept a new level only after the synced input has differed from it for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            Pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= BtnIn;
            sync_2  <= sync_1;
            level_q <= level;
            Pulse   <= level & ~level_q;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: generates the core clock-enable in halted, single-step and free-run modes with a PC breakpoint
module cpu_run_controller
    import cpu_ctrl_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000,
    parameter int CNT_W           = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               StepBtn,
    input  logic               RunSw,
    input  logic               BreakEn,
    input  logic [31:0]        BreakAddr,
    input  logic [31:0]        PCIn,
    output logic               CpuEn,
    output logic               Halted,
    output logic               BreakHit,
    output logic [CNT_W-1:0]   CycleCount,
    output logic [STATE_W-1:0] State
);

    localparam int DIV_W = $clog2(RUN_DIV) + 1;

    state_t           state;
    state_t           next_state;
    logic             run_sync_1;
    logic             run_req;
    logic             step_req;
    logic [DIV_W-1:0] div;
    logic             term;
    logic             brk_match;
    logic             run_fire;
    logic             en_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .Clk   (Clk),
        .Reset (Reset),
        .BtnIn (StepBtn),
        .Pulse (step_req)
    );

    assign term      = div == DIV_W'(RUN_DIV - 1);
    assign brk_match = BreakEn && (PCIn == BreakAddr);
    assign en_next   = (next_state == S_STEP) || run_fire;

    // Next state and the RUN-mode pulse decision; RunSw low always wins, breakpoint only checked at terminal count
    always_comb begin
        next_state = state;
        run_fire   = 1'b0;
        case (state)
            S_IDLE:  next_state = run_req ? S_RUN : step_req ? S_STEP : S_IDLE;
            S_STEP:  next_state = S_IDLE;
            S_RUN: begin
                next_state = !run_req ? S_IDLE : (term && brk_match) ? S_BREAK : S_RUN;
                run_fire   = run_req && term && !brk_match;
            end
            S_BREAK: next_state = !run_req ? S_IDLE : step_req ? S_STEP : S_BREAK;
            default: next_state = S_IDLE;
        endcase
    end

    // State register, registered enable, rate divider (runs only while staying in RUN) and executed-cycle counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_sync_1 <= 1'b0;
            run_req    <= 1'b0;
            state      <= S_IDLE;
            CpuEn      <= 1'b0;
            CycleCount <= '0;
            div        <= '0;
        end else begin
            run_sync_1 <= RunSw;
            run_req    <= run_sync_1;
            state      <= next_state;
            CpuEn      <= en_next;
            CycleCount <= en_next ? CycleCount + 1'b1 : CycleCount;
            div        <= (state == S_RUN && next_state == S_RUN && !term) ? div + 1'b1 : '0;
        end
    end

    assign Halted   = (state == S_IDLE) || (state == S_BREAK);
    assign BreakHit = state == S_BREAK;
    assign State    = state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: checks enable pulse timing, counting, breakpoint and reset against an event-time model
module tb_cpu_run_controller;

    localparam int DEB = 4;
    localparam int DIV = 3;
    localparam int CW  = 4;
    localparam int ST_IDLE = 0, ST_STEP = 1, ST_RUN = 2, ST_BREAK = 3;
    localparam int STEP_LAT = 2 + DEB + 2;
    localparam int RUN_LAT  = 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          StepBtn = 1'b0;
    logic          RunSw = 1'b0;
    logic          BreakEn = 1'b0;
    logic [31:0]   BreakAddr = '0;
    logic [31:0]   PCIn = '0;
    logic          CpuEn;
    logic          Halted;
    logic          BreakHit;
    logic [CW-1:0] CycleCount;
    logic [1:0]    State;

    cpu_run_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV),
        .CNT_W          (CW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .StepBtn    (StepBtn),
        .RunSw      (RunSw),
        .BreakEn    (BreakEn),
        .BreakAddr  (BreakAddr),
        .PCIn       (PCIn),
        .CpuEn      (CpuEn),
        .Halted     (Halted),
        .BreakHit   (BreakHit),
        .CycleCount (CycleCount),
        .State      (State)
    );

    always #5 Clk = ~Clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    int          exp_q[$];
    logic [31:0] pc = '0;
    logic        en_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic want;
        @(posedge Clk);
        #1;
        cyc++;
        if (en_prev) pc += 32'd4;
        PCIn = pc;
        want = exp_q.size() > 0 && exp_q[0] == cyc;
        if (want) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
        chk("cpu_en", 32'(CpuEn), 32'(want));
        en_prev = CpuEn;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_count();
        chk("cycle_count", 32'(CycleCount), 32'(exp_cnt % (1 << CW)));
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        StepBtn = 1'b0;
        RunSw = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        repeat (n) begin
            tick();
            chk("rst_state", 32'(State), ST_IDLE);
            chk("rst_count", 32'(CycleCount), 0);
            chk("rst_halted", 32'(Halted), 1);
            chk("rst_breakhit", 32'(BreakHit), 0);
        end
        Reset = 1'b0;
        pc = '0;
        PCIn = '0;
        en_prev = 1'b0;
    endtask

    task automatic press(input int hold);
        if (hold >= DEB) exp_q.push_back(cyc + STEP_LAT);
        StepBtn = 1'b1;
        ticks(hold);
        StepBtn = 1'b0;
        ticks(12);
        chk("press_state", 32'(State), ST_IDLE);
        chk_count();
    endtask

    task automatic run_burst(input int len);
        int t0;
        t0 = cyc;
        for (int c = t0 + RUN_LAT + DIV; c <= t0 + len + 2; c += DIV) exp_q.push_back(c);
        RunSw = 1'b1;
        ticks(len);
        chk("run_state", 32'(State), ST_RUN);
        chk("run_halted", 32'(Halted), 0);
        RunSw = 1'b0;
        ticks(3);
        chk("run_exit_state", 32'(State), ST_IDLE);
        chk_count();
    endtask

    initial begin
        int k;
        int b;
        int t0;
        do_reset(2);

        press(12);
        chk("one_step_count", 32'(CycleCount), 1);
        for (int i = 0; i < 3; i++) press(int'($urandom_range(1, DEB - 1)));
        for (int i = 0; i < 2; i++) press(int'($urandom_range(DEB, 10)));

        do_reset(2);
        run_burst(53);
        chk("wrap_count", 32'(CycleCount), 1);
        run_burst(int'($urandom_range(10, 40)));

        do_reset(2);
        k = int'($urandom_range(2, 5));
        BreakAddr = 32'(4 * k);
        BreakEn = 1'b1;
        t0 = cyc;
        for (int j = 1; j <= k; j++) exp_q.push_back(t0 + RUN_LAT + DIV * j);
        RunSw = 1'b1;
        ticks(RUN_LAT + DIV * (k + 1));
        chk("brk_state", 32'(State), ST_BREAK);
        chk("brk_hit", 32'(BreakHit), 1);
        chk("brk_halted", 32'(Halted), 1);
        ticks(5);
        chk("brk_hold_state", 32'(State), ST_BREAK);
        chk("brk_pc", PCIn, 32'(4 * k));
        chk_count();
        b = cyc;
        exp_q.push_back(b + STEP_LAT);
        StepBtn = 1'b1;
        ticks(STEP_LAT);
        chk("brk_step_state", 32'(State), ST_STEP);
        tick();
        chk("brk_step_pc", PCIn, 32'(4 * k + 4));
        tick();
        chk("brk_resume_state", 32'(State), ST_RUN);
        StepBtn = 1'b0;
        RunSw = 1'b0;
        ticks(3);
        chk("term_drop_state", 32'(State), ST_IDLE);
        chk_count();
        ticks(12);
        BreakEn = 1'b0;

        run_burst(DIV + DIV * int'($urandom_range(1, 4)));

        t0 = cyc;
        for (int c = t0 + RUN_LAT + DIV; c <= t0 + 40; c += DIV) exp_q.push_back(c);
        RunSw = 1'b1;
        ticks(int'($urandom_range(7, 20)));
        do_reset(2);

        t0 = cyc;
        exp_q.push_back(t0 + STEP_LAT);
        StepBtn = 1'b1;
        ticks(STEP_LAT);
        chk("step_state", 32'(State), ST_STEP);
        do_reset(2);
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
